// File: rtl/byte_data_memory.sv
// Byte-addressable 32-bit data memory with lane writes, extended loads,
// alignment checking and a hardware clear sweep after reset.
module byte_data_memory #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_error,
    output logic                  init_done
);

    localparam int W     = ADDR_WIDTH - 2;
    localparam int DEPTH = 1 << W;

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_e;

    state_e      state_q;
    logic [W-1:0] cnt_q;
    logic        ready_q;
    logic        done_q;
    logic        rvalid_q;
    logic        rerr_q;
    logic [31:0] rdata_q;
    logic [31:0] mem_q [DEPTH];

    logic [W-1:0] idx;
    logic [1:0]   lane;
    logic         accept;
    logic         bad;
    logic [31:0]  word_rd;
    logic [31:0]  shifted;
    logic [31:0]  load_ext;
    logic         rerr_d;
    logic [31:0]  rdata_d;

    logic         we;
    logic [W-1:0] wa;
    logic [31:0]  wd;
    logic [3:0]   wm;

    assign idx     = req_addr[ADDR_WIDTH-1:2];
    assign lane    = req_addr[1:0];
    assign accept  = req_valid & ready_q;
    assign word_rd = mem_q[idx];
    assign shifted = word_rd >> {lane, 3'b000};

    always_comb begin
        bad = 1'b0;
        unique case (req_size)
            2'b00:   bad = 1'b0;
            2'b01:   bad = req_addr[0];
            2'b10:   bad = |lane;
            default: bad = 1'b1;
        endcase
    end

    // Byte/halfword are right-aligned, then sign- or zero-extended
    always_comb begin
        load_ext = word_rd;
        unique case (req_size)
            2'b00: load_ext = {{24{shifted[7] & ~req_unsigned}}, shifted[7:0]};
            2'b01: load_ext = {{16{shifted[15] & ~req_unsigned}}, shifted[15:0]};
            default: load_ext = word_rd;
        endcase
    end

    always_comb begin
        rerr_d  = accept & bad;
        rdata_d = (accept & ~req_write & ~bad) ? load_ext : 32'h0;
    end

    // Single write port shared by the clear sweep and stores
    always_comb begin
        we = 1'b0;
        wa = idx;
        wd = req_wdata;
        wm = 4'h0;
        if (state_q == S_INIT) begin
            we = 1'b1;
            wa = cnt_q;
            wd = 32'h0;
            wm = 4'hF;
        end else if (accept & req_write & ~bad) begin
            we = 1'b1;
            unique case (req_size)
                2'b00: begin
                    wd = {4{req_wdata[7:0]}};
                    wm = 4'b0001 << lane;
                end
                2'b01: begin
                    wd = {2{req_wdata[15:0]}};
                    wm = req_addr[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    wd = req_wdata;
                    wm = 4'hF;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && we) begin
            for (int k = 0; k < 4; k++) begin
                if (wm[k]) begin
                    mem_q[wa][8*k +: 8] <= wd[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= S_INIT;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
            rvalid_q <= 1'b0;
            rerr_q   <= 1'b0;
            rdata_q  <= 32'h0;
        end else begin
            rvalid_q <= accept;
            rerr_q   <= rerr_d;
            rdata_q  <= rdata_d;
            unique case (state_q)
                S_INIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (&cnt_q) begin
                        state_q <= S_RUN;
                        ready_q <= 1'b1;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_RUN;
                end
            endcase
        end
    end

    assign req_ready = ready_q;
    assign init_done = done_q;
    assign rsp_valid = rvalid_q;
    assign rsp_error = rerr_q;
    assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_byte_data_memory.sv
// Directed and streaming checks of byte_data_memory against a
// reference memory model and a response scoreboard.
module tb_byte_data_memory;

    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_error;
    logic          init_done;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } rsp_t;

    rsp_t        sb[$];
    logic [31:0] ref_mem [16];

    always #5 clk = ~clk;

    byte_data_memory #(.ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_error    (rsp_error),
        .init_done    (init_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic w, input logic [1:0] sz,
                         input logic u, input logic [5:0] a,
                         input logic [31:0] wdat, output rsp_t r);
        logic [3:0]  i;
        logic [1:0]  ln;
        logic [7:0]  b;
        logic [15:0] h;
        i = a[5:2];
        ln = a[1:0];
        r.err = (sz == 2'b11) || (sz == 2'b01 && a[0]) ||
                (sz == 2'b10 && ln != 2'b00);
        r.data = 32'h0;
        if (!r.err) begin
            if (w) begin
                case (sz)
                    2'b00: ref_mem[i][8*ln +: 8] = wdat[7:0];
                    2'b01: ref_mem[i][16*a[1] +: 16] = wdat[15:0];
                    default: ref_mem[i] = wdat;
                endcase
            end else begin
                b = ref_mem[i][8*ln +: 8];
                h = ref_mem[i][16*a[1] +: 16];
                case (sz)
                    2'b00: r.data = u ? {24'h0, b} : {{24{b[7]}}, b};
                    2'b01: r.data = u ? {16'h0, h} : {{16{h[15]}}, h};
                    default: r.data = ref_mem[i];
                endcase
            end
        end
    endtask

    task automatic check_rsp(input string tag);
        rsp_t r;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL %s scoreboard empty observed=%0d expected=0",
                   tag, rsp_valid);
        end else begin
            r = sb.pop_front();
            chk({tag, ".valid"}, {31'h0, rsp_valid}, 32'h1);
            chk({tag, ".error"}, {31'h0, rsp_error}, {31'h0, r.err});
            chk({tag, ".rdata"}, rsp_rdata, r.data);
        end
    endtask

    task automatic issue(input string tag, input logic w,
                         input logic [1:0] sz, input logic u,
                         input logic [5:0] a, input logic [31:0] wdat,
                         input bit use_exp, input logic e_err,
                         input logic [31:0] e_data);
        rsp_t r;
        req_valid = 1'b1;
        req_write = w;
        req_size = sz;
        req_unsigned = u;
        req_addr = a;
        req_wdata = wdat;
        model(w, sz, u, a, wdat, r);
        if (use_exp) begin
            r.err = e_err;
            r.data = e_data;
        end
        sb.push_back(r);
        @(posedge clk);
        #1;
        check_rsp(tag);
    endtask

    task automatic idle(input string tag);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk(tag, {31'h0, rsp_valid}, 32'h0);
    endtask

    task automatic sweep(input string tag);
        reset_n = 1'b1;
        req_valid = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        chk({tag, ".ready15"}, {31'h0, req_ready}, 32'h0);
        chk({tag, ".done15"}, {31'h0, init_done}, 32'h0);
        @(posedge clk);
        #1;
        chk({tag, ".ready16"}, {31'h0, req_ready}, 32'h1);
        chk({tag, ".done16"}, {31'h0, init_done}, 32'h1);
        for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;
    endtask

    initial begin
        reset_n = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_size = 2'b00;
        req_unsigned = 1'b0;
        req_addr = '0;
        req_wdata = 32'h0;
        for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.ready", {31'h0, req_ready}, 32'h0);
        chk("rst.done", {31'h0, init_done}, 32'h0);
        chk("rst.valid", {31'h0, rsp_valid}, 32'h0);

        sweep("sweep1");
        for (int i = 0; i < 16; i++)
            issue("clr_ld", 1'b0, 2'b10, 1'b0, 6'(i * 4), 32'h0,
                  1'b1, 1'b0, 32'h0);
        issue("st_3c", 1'b1, 2'b10, 1'b0, 6'h3C, 32'hDEADBEEF, 0, 0, 0);
        issue("ld_3c", 1'b0, 2'b10, 1'b0, 6'h3C, 32'h0,
              1'b1, 1'b0, 32'hDEADBEEF);

        // Reset while a request is held: not accepted, outputs cleared
        reset_n = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_size = 2'b10;
        req_addr = 6'h3C;
        @(posedge clk);
        #1;
        chk("rrun.valid", {31'h0, rsp_valid}, 32'h0);
        chk("rrun.rdata", rsp_rdata, 32'h0);
        chk("rrun.error", {31'h0, rsp_error}, 32'h0);
        chk("rrun.ready", {31'h0, req_ready}, 32'h0);
        chk("rrun.done", {31'h0, init_done}, 32'h0);

        reset_n = 1'b1;
        req_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rmid.ready", {31'h0, req_ready}, 32'h0);
        sweep("sweep2");
        issue("clr_3c", 1'b0, 2'b10, 1'b0, 6'h3C, 32'h0, 1'b1, 1'b0, 32'h0);

        issue("st_10", 1'b1, 2'b10, 1'b0, 6'h10, 32'h80FF7F01, 0, 0, 0);
        issue("lb_13s", 1'b0, 2'b00, 1'b0, 6'h13, 32'h0, 1, 0, 32'hFFFFFF80);
        issue("lb_13u", 1'b0, 2'b00, 1'b1, 6'h13, 32'h0, 1, 0, 32'h00000080);
        issue("lh_12s", 1'b0, 2'b01, 1'b0, 6'h12, 32'h0, 1, 0, 32'hFFFF80FF);
        issue("lh_10s", 1'b0, 2'b01, 1'b0, 6'h10, 32'h0, 1, 0, 32'h00007F01);
        issue("lw_10", 1'b0, 2'b10, 1'b0, 6'h10, 32'h0, 1, 0, 32'h80FF7F01);

        issue("st_20", 1'b1, 2'b10, 1'b0, 6'h20, 32'h11223344, 0, 0, 0);
        issue("sb_21", 1'b1, 2'b00, 1'b0, 6'h21, 32'h000000AA, 0, 0, 0);
        issue("lw_20", 1'b0, 2'b10, 1'b0, 6'h20, 32'h0, 1, 0, 32'h1122AA44);

        issue("sh_2a", 1'b1, 2'b01, 1'b0, 6'h2A, 32'h0000BEEF, 0, 0, 0);
        issue("lw_28", 1'b0, 2'b10, 1'b0, 6'h28, 32'h0, 1, 0, 32'hBEEF0000);

        issue("sw_31", 1'b1, 2'b10, 1'b0, 6'h31, 32'hCAFEF00D, 1, 1, 32'h0);
        issue("lw_30", 1'b0, 2'b10, 1'b0, 6'h30, 32'h0, 1, 0, 32'h0);
        issue("lh_33", 1'b0, 2'b01, 1'b0, 6'h33, 32'h0, 1, 1, 32'h0);
        issue("sz11", 1'b0, 2'b11, 1'b0, 6'h20, 32'h0, 1, 1, 32'h0);
        idle("idle1");

        for (int n = 0; n < 20; n++)
            issue("stream", 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  6'($urandom_range(0, 63)), $urandom, 0, 0, 0);
        idle("idle2");

        checks++;
        assert (sb.size() == 0) else begin
            failures++;
            $error("FAIL sb_left observed=%0d expected=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
